call_request_issuer: RTL and testbench



---
 rtl/elevator_pkg.sv | 34 +++
 rtl/call_request_issuer_if.sv | 12 +
 rtl/call_request_issuer_fifo.sv | 55 +++++
 rtl/call_request_issuer.sv | 134 +++++++++++++
 tb/tb_call_request_issuer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared floor limits, request record and issuer state encoding for the elevator request path.
package elevator_pkg;
  localparam int   FLOOR_W   = 3;
  localparam int   MIN_FLOOR = 1;
  localparam int   MAX_FLOOR = 5;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef struct packed {
    floor_t src;
    floor_t dest;
    logic   dir;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP
  } issuer_state_t;

  function automatic logic req_legal(input floor_t src, input floor_t dest);
    return (src  >= floor_t'(MIN_FLOOR)) && (src  <= floor_t'(MAX_FLOOR)) &&
           (dest >= floor_t'(MIN_FLOOR)) && (dest <= floor_t'(MAX_FLOOR)) &&
           (src != dest);
  endfunction

  function automatic logic req_dir(input floor_t src, input floor_t dest);
    return (dest > src) ? DIR_UP : DIR_DOWN;
  endfunction
endpackage

// File: rtl/call_request_issuer_if.sv
// Passenger request push port: valid/ready handshake carrying source and destination floors.
interface call_request_issuer_if;
  import elevator_pkg::*;

  logic   req_valid;
  logic   req_ready;
  floor_t req_src;
  floor_t req_dest;

  modport master (output req_valid, output req_src, output req_dest, input req_ready);
  modport slave  (input req_valid, input req_src, input req_dest, output req_ready);
endinterface

// File: rtl/call_request_issuer_fifo.sv
// Request FIFO: head is read combinationally, a push is visible one cycle later.
// Push is ignored when full and pop when empty; the producer must honour full_o.
module req_fifo
  import elevator_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  req_t        push_dat_i,
  input  logic        pop_i,
  output req_t        pop_dat_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/call_request_issuer.sv
// Buffers passenger requests and drives set_clk strobes; accept to set_clk rise is 2 cycles, req_ready drops when full.
// CALL_REQUEST_DEDUP_EN: a request matching the FIFO tail or the in-flight request is accepted and dropped.
module call_request_issuer
  import elevator_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_CYC  = 1,
  parameter int GAP_CYC    = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  call_request_issuer_if.slave        req,
  output logic                        set_clk,
  output floor_t                      src_input,
  output floor_t                      dest_input,
  output logic                        direction_input,
  output logic                        busy,
  output logic                        err_reject,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  issuer_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             set_clk_q;
  logic             err_q;
  logic             err_d;
  req_t             cur_q;
  req_t             in_req;
  req_t             head_req;
  logic             full;
  logic             empty;
  logic             accept;
  logic             legal;
  logic             dup;
  logic             push;
  logic             pop;

  assign in_req = '{src: req.req_src, dest: req.req_dest, dir: req_dir(req.req_src, req.req_dest)};

  assign req.req_ready = !full;
  assign accept        = req.req_valid && !full;
  assign legal         = req_legal(req.req_src, req.req_dest);
  assign err_d         = accept && !legal;
  assign push          = accept && legal && !dup;
  assign pop           = (state_q == IDLE) && !empty;

`ifdef CALL_REQUEST_DEDUP_EN
  // The last pushed entry is the tail for as long as the FIFO is non-empty.
  logic [2*FLOOR_W-1:0] tail_q;
  logic                 in_flight;

  assign in_flight = state_q inside {SETUP, PULSE, HOLD};
  assign dup = (!empty && (tail_q == {in_req.src, in_req.dest})) ||
               (in_flight && (cur_q.src == in_req.src) && (cur_q.dest == in_req.dest));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= '0;
    end else if (push) begin
      tail_q <= {in_req.src, in_req.dest};
    end
  end
`else
  assign dup = 1'b0;
`endif

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (in_req),
    .pop_i      (pop),
    .pop_dat_o  (head_req),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      set_clk_q <= 1'b0;
      cur_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            cur_q   <= head_req;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          set_clk_q <= 1'b1;
          cnt_q     <= CNT_W'(PULSE_CYC - 1);
          state_q   <= PULSE;
        end
        PULSE: begin
          if (cnt_q == '0) begin
            set_clk_q <= 1'b0;
            state_q   <= HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          cnt_q   <= CNT_W'(GAP_CYC - 1);
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign set_clk         = set_clk_q;
  assign src_input       = cur_q.src;
  assign dest_input      = cur_q.dest;
  assign direction_input = cur_q.dir;
  assign err_reject      = err_q;
  assign busy            = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_call_request_issuer.sv
// Bench for call_request_issuer: vector table plus hand sequences, strobes checked against a request scoreboard.
module tb_call_request_issuer;
  localparam int PULSE = 1;
  localparam int GAP   = 25;
  localparam int FW    = elevator_pkg::FLOOR_W;

  typedef struct packed {
    logic [FW-1:0] src;
    logic [FW-1:0] dest;
    logic          dir;
  } exp_t;

  typedef struct {
    int src;
    int dest;
    bit legal;
    bit dir;
  } vec_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          set_clk, direction_input, busy, err_reject;
  logic [FW-1:0] src_input, dest_input;
  logic [2:0]    fifo_count;
  logic          set_clk3, dir3, busy3, err3;
  logic [FW-1:0] src3, dest3;
  logic [2:0]    fifo_count3;

  call_request_issuer_if req_if ();
  call_request_issuer_if req_if3 ();

  call_request_issuer dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req_if),
    .set_clk         (set_clk),
    .src_input       (src_input),
    .dest_input      (dest_input),
    .direction_input (direction_input),
    .busy            (busy),
    .err_reject      (err_reject),
    .fifo_count      (fifo_count)
  );

  call_request_issuer #(.PULSE_CYC(3)) dut3 (
    .clk             (clk),
    .rst             (rst3),
    .req             (req_if3),
    .set_clk         (set_clk3),
    .src_input       (src3),
    .dest_input      (dest3),
    .direction_input (dir3),
    .busy            (busy3),
    .err_reject      (err3),
    .fifo_count      (fifo_count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and strobe monitor for the main instance.
  exp_t          exp_q[$];
  exp_t          e_mon;
  int            n_strobes = 0;
  int            rise_cyc  = -1;
  int            prev_rise = -1;
  int            acc_cyc   = 0;
  logic          prev_set  = 1'b0;
  logic [2*FW:0] prev_data = '0;
  logic [2*FW:0] strobe_data = '0;
  logic [2*FW:0] cur_data;

  always @(negedge clk) begin
    cur_data = {src_input, dest_input, direction_input};
    if (rst) begin
      prev_set  = 1'b0;
      prev_data = cur_data;
    end else begin
      if (set_clk && !prev_set) begin
        n_strobes++;
        prev_rise   = rise_cyc;
        rise_cyc    = cyc;
        strobe_data = cur_data;
        check("data_stable_before_rise", cur_data, prev_data);
        check("strobe_has_request", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_mon = exp_q.pop_front();
          check("strobe_data", cur_data, e_mon);
        end
      end else if (set_clk || prev_set) begin
        check("data_stable_around_strobe", cur_data, strobe_data);
      end
      if (!set_clk && prev_set) begin
        check("pulse_width", cyc - rise_cyc, PULSE);
      end
      prev_set  = set_clk;
      prev_data = cur_data;
    end
  end

  int   rises3    = 0;
  logic prev_set3 = 1'b0;
  always @(negedge clk) begin
    if (set_clk3 && !prev_set3) rises3++;
    prev_set3 = set_clk3;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int s, input int d, input bit exp_ok, input bit exp_dir,
                      input bit exp_enq, output int waited);
    waited = 0;
    req_if.req_valid = 1'b1;
    req_if.req_src   = FW'(s);
    req_if.req_dest  = FW'(d);
    while (!req_if.req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait_timeout", waited >= 300, 0);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (exp_ok && exp_enq) exp_q.push_back('{src: FW'(s), dest: FW'(d), dir: exp_dir});
    check("err_reject_after_accept", err_reject, !exp_ok);
    req_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   w, s0, n, exp_n, idle_cyc, r_before;

    vecs[0] = '{2, 5, 1'b1, 1'b1};
    vecs[1] = '{4, 3, 1'b1, 1'b0};
    vecs[2] = '{3, 3, 1'b0, 1'b0};
    vecs[3] = '{0, 2, 1'b0, 1'b1};
    vecs[4] = '{6, 1, 1'b0, 1'b0};
    vecs[5] = '{1, 5, 1'b1, 1'b1};
    vecs[6] = '{5, 1, 1'b1, 1'b0};

    req_if.req_valid  = 1'b0;
    req_if.req_src    = '0;
    req_if.req_dest   = '0;
    req_if3.req_valid = 1'b0;
    req_if3.req_src   = '0;
    req_if3.req_dest  = '0;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    check("reset_set_clk", set_clk, 0);
    check("reset_src_input", src_input, 0);
    check("reset_dest_input", dest_input, 0);
    check("reset_direction", direction_input, 0);
    check("reset_err_reject", err_reject, 0);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_req_ready", req_if.req_ready, 1);

    // One request at a time from idle.
    for (int i = 0; i < 7; i++) begin
      s0 = n_strobes;
      push(vecs[i].src, vecs[i].dest, vecs[i].legal, vecs[i].dir, 1'b1, w);
      check("fifo_count_after_accept", fifo_count, vecs[i].legal ? 1 : 0);
      wait_idle(100);
      repeat (4) @(negedge clk);
      check("strobe_count", n_strobes - s0, vecs[i].legal ? 1 : 0);
      if (vecs[i].legal) check("accept_to_rise", rise_cyc - acc_cyc, 2);
    end

    // Back-to-back pushes on consecutive edges.
    s0 = n_strobes;
    push(2, 5, 1'b1, 1'b1, 1'b1, w);
    push(3, 4, 1'b1, 1'b1, 1'b1, w);
    wait_idle(200);
    idle_cyc = cyc;
    check("b2b_strobes", n_strobes - s0, 2);
    check("b2b_rise_spacing", rise_cyc - prev_rise, PULSE + GAP + 3);
    check("busy_fall_after_gap", idle_cyc - rise_cyc, PULSE + GAP + 1);
    repeat (2) @(negedge clk);

    // Fill the FIFO while the first request sits in its gap.
    push(1, 2, 1'b1, 1'b1, 1'b1, w);
    n = 0;
    while (!set_clk && n < 20) begin @(negedge clk); n++; end
    while (set_clk && n < 20) begin @(negedge clk); n++; end
    check("full_seq_strobe_timeout", n >= 20, 0);
    repeat (2) @(negedge clk);
    push(2, 3, 1'b1, 1'b1, 1'b1, w);
    push(3, 4, 1'b1, 1'b1, 1'b1, w);
    push(4, 5, 1'b1, 1'b1, 1'b1, w);
    push(5, 4, 1'b1, 1'b0, 1'b1, w);
    check("full_fifo_count", fifo_count, 4);
    check("full_req_ready", req_if.req_ready, 0);
    push(4, 3, 1'b1, 1'b0, 1'b1, w);
    check("held_request_waited", w > 0, 1);
    check("count_after_held_accept", fifo_count, 4);
    wait_idle(400);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // Identical request pushed twice.
    s0 = n_strobes;
    push(2, 5, 1'b1, 1'b1, 1'b1, w);
`ifdef CALL_REQUEST_DEDUP_EN
    push(2, 5, 1'b1, 1'b1, 1'b0, w);
    exp_n = 1;
`else
    push(2, 5, 1'b1, 1'b1, 1'b1, w);
    exp_n = 2;
`endif
    wait_idle(200);
    check("dup_strobe_count", n_strobes - s0, exp_n);
    check("dup_scoreboard_drained", exp_q.size(), 0);

    // Reset in the second high cycle of a 3-cycle strobe.
    req_if3.req_valid = 1'b1;
    req_if3.req_src   = FW'(1);
    req_if3.req_dest  = FW'(4);
    @(posedge clk);
    @(negedge clk);
    req_if3.req_src   = FW'(2);
    req_if3.req_dest  = FW'(5);
    @(posedge clk);
    @(negedge clk);
    req_if3.req_valid = 1'b0;
    n = 0;
    while (!set_clk3 && n < 20) begin @(negedge clk); n++; end
    check("dut3_strobe_seen", set_clk3, 1);
    @(negedge clk);
    check("dut3_second_high_cycle", set_clk3, 1);
    check("dut3_strobe_data", {src3, dest3, dir3}, {3'd1, 3'd4, 1'b1});
    check("dut3_count_before_rst", fifo_count3, 1);
    r_before = rises3;
    #2 rst3 = 1'b1;
    #1;
    check("dut3_set_clk_async_low", set_clk3, 0);
    check("dut3_count_cleared", fifo_count3, 0);
    check("dut3_busy_cleared", busy3, 0);
    check("dut3_err_reject", err3, 0);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (60) @(negedge clk);
    check("dut3_no_strobe_after_reset", rises3 - r_before, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
